// File: rtl/video_timing_if.sv
// Raster timing bundle carried from the timing generator to the overlay display stage.
// All members are registered in the generator and change on the same clock edge.
interface video_timing_if #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12
);
  logic              hs_out;
  logic              vs_out;
  logic              de_out;
  logic [X_BITS-1:0] act_x;
  logic [Y_BITS-1:0] act_y;
  logic              frame_start;

  modport master (
    output hs_out, vs_out, de_out, act_x, act_y, frame_start
  );

  modport slave (
    input hs_out, vs_out, de_out, act_x, act_y, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Progressive raster timing generator: free-running h/v counters with every output
// registered once from the current count, so all outputs share one clock of latency.
module video_timing_gen #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int H_ACT  = 1280,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int V_ACT  = 720,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic            pix_clk,
  input  logic            rstn,
  input  logic            en,
  video_timing_if.master  vid
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [X_BITS-1:0] H_LAST  = X_BITS'(H_TOTAL - 1);
  localparam logic [X_BITS-1:0] H_SEND  = X_BITS'(H_SYNC);
  localparam logic [X_BITS-1:0] H_ASTRT = X_BITS'(H_SYNC + H_BP);
  localparam logic [X_BITS-1:0] H_AEND  = X_BITS'(H_SYNC + H_BP + H_ACT);
  localparam logic [Y_BITS-1:0] V_LAST  = Y_BITS'(V_TOTAL - 1);
  localparam logic [Y_BITS-1:0] V_SEND  = Y_BITS'(V_SYNC);
  localparam logic [Y_BITS-1:0] V_ASTRT = Y_BITS'(V_SYNC + V_BP);
  localparam logic [Y_BITS-1:0] V_AEND  = Y_BITS'(V_SYNC + V_BP + V_ACT);

  logic [X_BITS-1:0] h_cnt_q, h_cnt_d;
  logic [Y_BITS-1:0] v_cnt_q, v_cnt_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              de_q, de_d;
  logic [X_BITS-1:0] act_x_q, act_x_d;
  logic [Y_BITS-1:0] act_y_q, act_y_d;
  logic              fs_q, fs_d;

  logic h_wrap, v_wrap;
  logic h_sync, v_sync;
  logic h_active, v_active;

  always_comb begin
    h_wrap   = (h_cnt_q == H_LAST);
    v_wrap   = (v_cnt_q == V_LAST);
    h_sync   = (h_cnt_q < H_SEND);
    v_sync   = (v_cnt_q < V_SEND);
    h_active = (h_cnt_q >= H_ASTRT) && (h_cnt_q < H_AEND);
    v_active = (v_cnt_q >= V_ASTRT) && (v_cnt_q < V_AEND);

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    act_x_d = act_x_q;
    act_y_d = act_y_q;
    de_d    = 1'b0;
    fs_d    = 1'b0;

    // While en is low the counters and sync/coordinate outputs freeze; DE and
    // frame_start drop so a stalled pixel is never presented twice.
    if (en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + X_BITS'(1);
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + Y_BITS'(1);
      end
      hs_d    = h_sync ? HS_POL : ~HS_POL;
      vs_d    = v_sync ? VS_POL : ~VS_POL;
      de_d    = h_active && v_active;
      act_x_d = h_active ? (h_cnt_q - H_ASTRT) : '0;
      act_y_d = v_active ? (v_cnt_q - V_ASTRT) : '0;
      fs_d    = (h_cnt_q == H_ASTRT) && (v_cnt_q == V_ASTRT);
    end
  end

  always_ff @(posedge pix_clk) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      act_x_q <= '0;
      act_y_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      act_x_q <= act_x_d;
      act_y_q <= act_y_d;
      fs_q    <= fs_d;
    end
  end

  assign vid.hs_out      = hs_q;
  assign vid.vs_out      = vs_q;
  assign vid.de_out      = de_q;
  assign vid.act_x       = act_x_q;
  assign vid.act_y       = act_y_q;
  assign vid.frame_start = fs_q;

endmodule
